// File: rtl/reverse_number_radix_if.sv
// Start/done handshake bundle for the iterative radix digit reverser.
// The host drives start/din; the reverser returns status and result fields.
interface reverse_number_radix_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CW    = $clog2(WIDTH + 1)
);
    logic             start;
    logic [WIDTH-1:0] din;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dout;
    logic [CW-1:0]    ndigits;
    logic             ovf;
    logic             pal;

    modport master (
        output start, din,
        input  busy, done, dout, ndigits, ovf, pal
    );

    modport slave (
        input  start, din,
        output busy, done, dout, ndigits, ovf, pal
    );
endinterface

// File: rtl/reverse_number_radix.sv
// Iterative digit reverser: one radix-RADIX digit per clock, level start/done handshake.
// Returns reversed value (mod 2^WIDTH), significant-digit count, overflow and palindrome flags.
module reverse_number_radix #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned RADIX = 10
) (
    input logic                   clk,
    input logic                   rst,
    reverse_number_radix_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);
    // Wide enough for re*RADIX + digit without loss, and to hold RADIX itself.
    localparam int unsigned SW = WIDTH + $clog2(RADIX) + 1;

    if (RADIX < 2 || RADIX > 16) begin : g_bad_radix
        $error("reverse_number_radix: RADIX must be in 2..16");
    end
    if (WIDTH < 2) begin : g_bad_width
        $error("reverse_number_radix: WIDTH must be >= 2");
    end

    typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] x_q, re_q, orig_q, dout_q;
    logic [CW-1:0]    cnt_q, ndigits_q;
    logic             ovf_acc_q, ovf_q, pal_q, busy_q, done_q;

    logic [SW-1:0]    x_wide, sum_wide;
    logic [WIDTH-1:0] digit, quot;
    logic             sum_ovf;

    always_comb begin
        x_wide   = SW'(x_q);
        digit    = WIDTH'(x_wide % SW'(RADIX));
        quot     = WIDTH'(x_wide / SW'(RADIX));
        sum_wide = SW'(re_q) * SW'(RADIX) + SW'(digit);
        sum_ovf  = |sum_wide[SW-1:WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            x_q       <= '0;
            re_q      <= '0;
            orig_q    <= '0;
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
            dout_q    <= '0;
            ndigits_q <= '0;
            ovf_q     <= 1'b0;
            pal_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        x_q       <= bus.din;
                        orig_q    <= bus.din;
                        re_q      <= '0;
                        cnt_q     <= '0;
                        ovf_acc_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= StIter;
                    end
                end
                StIter: begin
                    if (x_q != '0) begin
                        re_q  <= sum_wide[WIDTH-1:0];
                        x_q   <= quot;
                        cnt_q <= cnt_q + CW'(1);
                        if (sum_ovf) begin
                            ovf_acc_q <= 1'b1;
                        end
                    end else begin
                        dout_q    <= re_q;
                        ndigits_q <= cnt_q;
                        ovf_q     <= ovf_acc_q;
                        pal_q     <= !ovf_acc_q && (re_q == orig_q);
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= StDone;
                    end
                end
                StDone: begin
                    // Holding start keeps us here so a level request cannot retrigger.
                    if (!bus.start) begin
                        done_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.dout    = dout_q;
    assign bus.ndigits = ndigits_q;
    assign bus.ovf     = ovf_q;
    assign bus.pal     = pal_q;
endmodule

// File: tb/tb_reverse_number_radix.sv
// Self-checking bench: three reverser instances (R10/W16, R2/W8, R16/W16) driven
// from a vector table through a scoreboard, plus handshake and async-reset sequences.
module tb_reverse_number_radix;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reverse_number_radix_if #(.WIDTH(16)) ia ();
    reverse_number_radix_if #(.WIDTH(8))  ib ();
    reverse_number_radix_if #(.WIDTH(16)) ic ();

    reverse_number_radix #(.WIDTH(16), .RADIX(10)) u_a (.clk(clk), .rst(rst), .bus(ia));
    reverse_number_radix #(.WIDTH(8),  .RADIX(2))  u_b (.clk(clk), .rst(rst), .bus(ib));
    reverse_number_radix #(.WIDTH(16), .RADIX(16)) u_c (.clk(clk), .rst(rst), .bus(ic));

    typedef struct {
        int          inst;
        logic [15:0] din;
        logic [15:0] dout;
        int          nd;
        bit          ovf;
        bit          pal;
    } vec_t;

    vec_t tab[$];
    vec_t sb_q[$];
    int   nvec = 0;
    int   nmis = 0;

    task automatic check(input string name, input longint act, input longint exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t model(input int inst, input int radix, input int width,
                                   input logic [15:0] d);
        vec_t            v;
        longint unsigned x, re, lim;
        v.inst = inst;
        v.din  = d;
        x      = d;
        re     = 0;
        lim    = (64'd1 << width) - 1;
        v.nd   = 0;
        v.ovf  = 0;
        while (x != 0) begin
            re = re * radix + x % radix;
            if (re > lim) v.ovf = 1;
            re = re & lim;
            x  = x / radix;
            v.nd++;
        end
        v.dout = 16'(re);
        v.pal  = !v.ovf && (re == longint'(d));
        return v;
    endfunction

    function automatic void add(input int inst, input logic [15:0] d, input logic [15:0] q,
                                input int nd, input bit ovf, input bit pal);
        vec_t v;
        v.inst = inst; v.din = d; v.dout = q; v.nd = nd; v.ovf = ovf; v.pal = pal;
        tab.push_back(v);
    endfunction

    task automatic set_in(input int inst, input logic s, input logic [15:0] d);
        case (inst)
            0:       begin ia.start = s; ia.din = d;      end
            1:       begin ib.start = s; ib.din = d[7:0]; end
            default: begin ic.start = s; ic.din = d;      end
        endcase
    endtask

    function automatic logic get_done(input int inst);
        case (inst)
            0:       return ia.done;
            1:       return ib.done;
            default: return ic.done;
        endcase
    endfunction

    function automatic logic get_busy(input int inst);
        case (inst)
            0:       return ia.busy;
            1:       return ib.busy;
            default: return ic.busy;
        endcase
    endfunction

    task automatic get_out(input int inst, output logic [15:0] q, output int nd,
                           output bit ovf, output bit pal);
        case (inst)
            0:       begin q = ia.dout; nd = int'(ia.ndigits); ovf = ia.ovf; pal = ia.pal; end
            1:       begin q = {8'd0, ib.dout}; nd = int'(ib.ndigits); ovf = ib.ovf;
                           pal = ib.pal; end
            default: begin q = ic.dout; nd = int'(ic.ndigits); ovf = ic.ovf; pal = ic.pal; end
        endcase
    endtask

    // Start at edge k, then count edges until done and cycles spent busy.
    task automatic run_op(input int inst, input logic [15:0] d, input bit hold,
                          output int lat, output int bcnt);
        @(negedge clk);
        set_in(inst, 1'b1, d);
        @(posedge clk);
        lat  = 0;
        bcnt = 0;
        @(negedge clk);
        while (!get_done(inst) && lat < 40) begin
            if (get_busy(inst)) bcnt++;
            if (!hold) set_in(inst, 1'b0, ~d);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!get_done(inst)) begin
            nvec++;
            nmis++;
            $display("FAIL timeout: inst %0d din %0d no done after %0d cycles", inst, d, lat);
        end
    endtask

    task automatic do_vec(input vec_t v, input bit hold);
        vec_t        e;
        int          lat, bcnt, nd;
        logic [15:0] q;
        bit          ovf, pal;
        sb_q.push_back(v);
        run_op(v.inst, v.din, hold, lat, bcnt);
        e = sb_q.pop_front();
        get_out(e.inst, q, nd, ovf, pal);
        check($sformatf("dout[%0d:%0d]", e.inst, e.din), longint'(q), longint'(e.dout));
        check($sformatf("ndigits[%0d:%0d]", e.inst, e.din), nd, e.nd);
        check($sformatf("ovf[%0d:%0d]", e.inst, e.din), longint'(ovf), longint'(e.ovf));
        check($sformatf("pal[%0d:%0d]", e.inst, e.din), longint'(pal), longint'(e.pal));
        check($sformatf("latency[%0d:%0d]", e.inst, e.din), lat, e.nd + 1);
        check($sformatf("busy_cycles[%0d:%0d]", e.inst, e.din), bcnt, e.nd + 1);
        check($sformatf("busy_at_done[%0d:%0d]", e.inst, e.din), longint'(get_busy(e.inst)), 0);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_busy"},    longint'(ia.busy), 0);
        check({tag, "_done"},    longint'(ia.done), 0);
        check({tag, "_dout"},    longint'(ia.dout), 0);
        check({tag, "_ndigits"}, longint'(ia.ndigits), 0);
        check({tag, "_ovf"},     longint'(ia.ovf), 0);
        check({tag, "_pal"},     longint'(ia.pal), 0);
    endtask

    initial begin
        vec_t v;
        add(0, 16'd1230,  16'd321,   4, 0, 0);
        add(0, 16'd0,     16'd0,     0, 0, 1);
        add(0, 16'd12321, 16'd12321, 5, 0, 1);
        add(0, 16'd19999, 16'd34455, 5, 1, 0);
        add(0, 16'd65535, 16'd53556, 5, 0, 0);
        add(0, 16'd10000, 16'd1,     5, 0, 0);
        add(0, 16'd1,     16'd1,     1, 0, 1);
        add(1, 16'h000D,  16'h000B,  4, 0, 0);
        add(1, 16'h0081,  16'h0081,  8, 0, 1);
        add(1, 16'h0080,  16'h0001,  8, 0, 0);
        add(1, 16'h0006,  16'h0003,  3, 0, 0);
        add(1, 16'h00FF,  16'h00FF,  8, 0, 1);
        add(2, 16'h0AB3,  16'h03BA,  3, 0, 0);
        add(2, 16'hFFFF,  16'hFFFF,  4, 0, 1);
        add(2, 16'h1000,  16'h0001,  4, 0, 0);
        add(2, 16'h1234,  16'h4321,  4, 0, 0);

        set_in(0, 1'b0, 16'd0);
        set_in(1, 1'b0, 16'd0);
        set_in(2, 1'b0, 16'd0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset");
        @(negedge clk);
        rst = 1'b0;

        foreach (tab[i]) do_vec(tab[i], 1'b0);

        for (int i = 0; i < 8; i++) begin
            v = model(0, 10, 16, 16'($urandom_range(0, 65535)));
            do_vec(v, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            v = model(2, 16, 16, 16'($urandom_range(0, 65535)));
            do_vec(v, 1'b0);
        end

        // Level start held past done: must park in DONE with stable outputs.
        v = model(0, 10, 16, 16'd12321);
        do_vec(v, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_done", longint'(ia.done), 1);
            check("hold_busy", longint'(ia.busy), 0);
            check("hold_dout", longint'(ia.dout), 12321);
        end
        set_in(0, 1'b0, 16'd0);
        @(posedge clk);
        @(negedge clk);
        check("drop_done", longint'(ia.done), 0);
        check("idle_keeps_dout", longint'(ia.dout), 12321);
        v = model(0, 10, 16, 16'd45);
        do_vec(v, 1'b0);

        // Async reset between edges while iterating on 1230.
        @(negedge clk);
        set_in(0, 1'b1, 16'd1230);
        @(posedge clk);
        @(negedge clk);
        set_in(0, 1'b0, 16'd0);
        @(posedge clk);
        #2;
        check("pre_reset_busy", longint'(ia.busy), 1);
        rst = 1'b1;
        #1;
        check_cleared("midreset");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("post_reset_busy", longint'(ia.busy), 0);
            check("post_reset_done", longint'(ia.done), 0);
        end
        v = model(0, 10, 16, 16'd7);
        do_vec(v, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
